// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-chained segments, with sum/carry/overflow/zero flags.
// Latency STAGES cycles: a beat captured at a rising edge E is presented after edge E+STAGES-1; 1 beat/cycle.
// Backpressure: the whole pipe freezes while out_valid=1 and out_ready=0; in_ready mirrors that advance condition.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in1 = A, in2 = B, op_sub selects A-B
//   out_valid/out_ready   result handshake; sum_out, carry_out, ovf_out, zero_out
// Build option: define PIPE_ADDER_SAT_EN to saturate sum_out on signed overflow.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             ovf_out,
  output logic             zero_out
);

  // WIDTH must be a multiple of STAGES.
  localparam int SEG = WIDTH / STAGES;
  localparam int L   = STAGES - 1;

  logic advance;

  // Inputs seen by each stage: the port for stage 0, the previous stage's registers otherwise.
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];

  // Stage registers. a/b hold only the not-yet-consumed upper segments (consumed ones are zeroed),
  // s accumulates the lower partial sums so they leave aligned with the top segment.
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_d [STAGES];
  logic             c_q [STAGES];
  logic             v_d [STAGES];
  logic             v_q [STAGES];

  logic             ovf_d;
  logic             ovf_q;
  logic             zero_d;
  logic             zero_q;
  logic [SEG:0]     seg_res;

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic sat_neg_d;
  logic sat_neg_q;
`endif

  always_comb begin
    advance = ~v_q[L] | out_ready;

    // Subtract is A + ~B + 1: the +1 enters as the stage-0 carry-in.
    st_a[0] = in1;
    st_b[0] = op_sub ? ~in2 : in2;
    st_c[0] = op_sub;
    st_s[0] = '0;
    // Only sampled when advance=1, where in_ready=1, so this equals in_valid & in_ready.
    st_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_c[k] = c_q[k-1];
      st_s[k] = s_q[k-1];
      st_v[k] = v_q[k-1];
    end

    seg_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_res = {1'b0, st_a[k][k*SEG +: SEG]}
              + {1'b0, st_b[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, st_c[k]};
      s_d[k]                 = st_s[k];
      s_d[k][k*SEG +: SEG]   = seg_res[SEG-1:0];
      c_d[k]                 = seg_res[SEG];
      a_d[k]                 = st_a[k];
      a_d[k][k*SEG +: SEG]   = '0;
      b_d[k]                 = st_b[k];
      b_d[k][k*SEG +: SEG]   = '0;
      v_d[k]                 = st_v[k];
    end

    // The last stage still sees the top segment of A and B', so the sign bits are available here.
    ovf_d = (st_a[L][WIDTH-1] == st_b[L][WIDTH-1]) & (s_d[L][WIDTH-1] != st_a[L][WIDTH-1]);
`ifdef PIPE_ADDER_SAT_EN
    sat_neg_d = st_a[L][WIDTH-1];
    // A saturated value is never zero.
    zero_d    = ovf_d ? 1'b0 : ~|s_d[L];
`else
    zero_d    = ~|s_d[L];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
      sat_neg_q <= 1'b0;
`endif
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        // Bubbles do not overwrite data, so the output holds its last result while idle.
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_d[L]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
`ifdef PIPE_ADDER_SAT_EN
        sat_neg_q <= sat_neg_d;
`endif
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = v_q[L];
  assign carry_out = c_q[L];
  assign ovf_out   = ovf_q;
  assign zero_out  = zero_q;

`ifdef PIPE_ADDER_SAT_EN
  // Saturation mux sits after the last register; ovf_q is 0 in reset so sum_out reads 0 then.
  assign sum_out = ovf_q ? (sat_neg_q ? SAT_NEG : SAT_POS) : s_q[L];
`else
  assign sum_out = s_q[L];
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed vector table, stall/throughput/reset sequences and a random run.
// Latency: checked against STAGES edges counted from the capturing edge.
// Backpressure: exercised with held and randomised out_ready.
module tb_pipe_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in1 = '0;
  logic [WIDTH-1:0] in2 = '0;
  logic             op_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             ovf_out;
  logic             zero_out;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .carry_out(carry_out), .ovf_out(ovf_out), .zero_out(zero_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    logic             z;
  } exp_t;

  // Reference: full-width add with no segmentation.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    exp_t r;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    r.s  = full[WIDTH-1:0];
    r.c  = full[WIDTH];
    r.o  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
    if (SAT && r.o) r.s = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    r.z  = (r.s == '0);
    return r;
  endfunction

  // Scoreboard / monitor, sampled on the falling edge (inputs only change just after a rising edge).
  exp_t             sbq[$];
  int               pop_cnt = 0;
  int               last_pop_cyc = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH+3:0] prev_out = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {out_valid, carry_out, ovf_out, zero_out, sum_out}, prev_out);
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, carry_out, ovf_out, zero_out, sum_out};
      if (out_valid && out_ready) begin
        chk("sb_has_entry", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_sum", sum_out, e.s);
          chk("sb_carry", carry_out, e.c);
          chk("sb_ovf", ovf_out, e.o);
          chk("sb_zero", zero_out, e.z);
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (in_valid && in_ready) sbq.push_back(model(in1, in2, op_sub));
    end
  end

  // Present a beat and hold it until a rising edge takes it; returns at that edge + 1.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    logic acc;
    acc = 1'b0;
    in1 = a; in2 = b; op_sub = sub; in_valid = 1'b1;
    for (int i = 0; i < 1000 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sbq.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    logic             z;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int edges;
    int p0;
    int c0;
    int gap;
    bit rnd_on;

    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h80000000, 32'h00000001, 1'b1, SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'h12345678, 32'h0000FFFF, 1'b0, 32'h12355677, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, SAT ? 32'h80000000 : 32'h00000000, 1'b1, 1'b1, !SAT};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b0, 1'b1, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", ovf_out, 0);
    chk("rst_zero", zero_out, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table: one beat at a time, latency and all flags against hand values
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub);
      edges = 1;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk);
        #1;
        edges++;
      end
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_latency", i), 64'(edges), 64'(STAGES));
      chk($sformatf("v%0d_sum", i), sum_out, vecs[i].s);
      chk($sformatf("v%0d_carry", i), carry_out, vecs[i].c);
      chk($sformatf("v%0d_ovf", i), ovf_out, vecs[i].o);
      chk($sformatf("v%0d_zero", i), zero_out, vecs[i].z);
      @(posedge clk);
      #1;
    end

    // Stall: fill, hold a refused beat at the input, then release
    out_ready = 1'b0;
    send(32'd1, 32'd2, 1'b0);
    send(32'd3, 32'd4, 1'b0);
    send(32'd10, 32'd3, 1'b1);
    for (int t = 0; t < 3 * STAGES && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    in1 = 32'd100; in2 = 32'd200; op_sub = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_head_sum", sum_out, 32'd3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'd100, 32'd200, 1'b0);
    drain();

    // Back-to-back: 16 beats, one per cycle in and out
    p0 = pop_cnt;
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(32'h01010101 * i, 32'h00FFFFF0 + i, 1'(i % 2));
    chk("tp_accept_cycles", 64'(cyc - c0), 64'd16);
    for (int t = 0; t < 100 && (pop_cnt - p0) < 16; t++) @(posedge clk);
    #1;
    chk("tp_pop_cnt", 64'(pop_cnt - p0), 64'd16);
    chk("tp_last_pop_cyc", 64'(last_pop_cyc - c0), 64'(15 + STAGES));
    drain();

    // Random traffic with random backpressure
    p0 = pop_cnt;
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          send($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("rnd_pop_cnt", 64'(pop_cnt - p0), 64'd64);

    // Reset with three beats in flight
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h1, 1'b0);
    send(32'h7FFFFFFF, 32'h1, 1'b0);
    send(32'h5, 32'h7, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum_out, 0);
    chk("mid_rst_carry", carry_out, 0);
    chk("mid_rst_ovf", ovf_out, 0);
    chk("mid_rst_zero", zero_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    p0 = pop_cnt;
    send(32'h10, 32'h20, 1'b0);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("post_rst_first_sum", sum_out, 32'h30);
    drain();
    chk("post_rst_pop_cnt", 64'(pop_cnt - p0), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
